// File: rtl/ucsbece154_icache.sv
// Direct-mapped instruction cache: combinational hit path, single-burst line refill.
// Tag/data arrays are left unreset; only the valid bits, fill state and line base are cleared.
module ucsbece154_icache #(
    parameter int NUM_SETS    = 8,
    parameter int BLOCK_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReadEnable,
    input  logic [31:0] ReadAddress,
    output logic [31:0] Instruction,
    output logic        Ready,
    output logic        Busy,
    output logic        MemReadRequest,
    output logic [31:0] MemReadAddress,
    input  logic [31:0] MemDataIn,
    input  logic        MemDataReady
);
    localparam int OFF_W  = $clog2(BLOCK_WORDS);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int LINE_W = 32 - OFF_W - 2;
    localparam int TAG_W  = LINE_W - IDX_W;
    localparam logic [OFF_W-1:0] LAST = OFF_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

    state_t              r_state, w_next;
    logic [31:0]         r_data [NUM_SETS][BLOCK_WORDS];
    logic [TAG_W-1:0]    r_tag  [NUM_SETS];
    logic [NUM_SETS-1:0] r_valid;
    logic [LINE_W-1:0]   r_line;
    logic [OFF_W-1:0]    r_cnt;

    logic [OFF_W-1:0] w_off;
    logic [IDX_W-1:0] w_idx, w_fidx;
    logic [TAG_W-1:0] w_tag, w_ftag;
    logic             w_hit, w_miss, w_fill_we, w_fill_done;
    logic             w_unused;

    assign w_off    = ReadAddress[OFF_W+1:2];
    assign w_idx    = ReadAddress[OFF_W+2 +: IDX_W];
    assign w_tag    = ReadAddress[31 -: TAG_W];
    assign w_fidx   = r_line[IDX_W-1:0];
    assign w_ftag   = r_line[LINE_W-1 -: TAG_W];
    assign w_unused = &{1'b0, ReadAddress[1:0]};

    assign w_hit       = (r_state == IDLE) && ReadEnable && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_miss      = (r_state == IDLE) && ReadEnable && !w_hit;
    assign w_fill_we   = (r_state == FILL) && MemDataReady;
    assign w_fill_done = w_fill_we && (r_cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        Ready          = 1'b0;
        Instruction    = 32'd0;
        Busy           = 1'b0;
        MemReadRequest = 1'b0;
        MemReadAddress = 32'd0;
        case (r_state)
            IDLE: begin
                Ready       = w_hit;
                Instruction = w_hit ? r_data[w_idx][w_off] : 32'd0;
                if (w_miss) w_next = REQ;
            end
            REQ: begin
                Busy           = 1'b1;
                MemReadRequest = 1'b1;
                MemReadAddress = {r_line, {(OFF_W+2){1'b0}}};
                w_next         = FILL;
            end
            FILL: begin
                Busy           = 1'b1;
                MemReadAddress = {r_line, {(OFF_W+2){1'b0}}};
                if (w_fill_done) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // The line base is captured only on an IDLE miss, so core-side changes mid-fill are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_cnt   <= '0;
            r_line  <= '0;
        end else begin
            if (w_miss)      r_line <= ReadAddress[31:OFF_W+2];
            if (w_fill_we)   r_cnt  <= w_fill_done ? '0 : r_cnt + 1'b1;
            if (w_fill_done) r_valid[w_fidx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill_we)   r_data[w_fidx][r_cnt] <= MemDataIn;
        if (w_fill_done) r_tag[w_fidx]         <= w_ftag;
    end
endmodule

// File: doc/ucsbece154_icache.md
UCSBECE154_ICACHE -- requirements
Module: ucsbece154_icache

Interface
REQ-001 Parameter NUM_SETS, default 8, gives the number of direct-mapped lines and SHALL be a power of 2 and at least 2.
REQ-002 Parameter BLOCK_WORDS, default 4, gives the words per line and SHALL equal the burst length of the downstream instruction memory.
REQ-003 Ports SHALL be exactly the following, clock and reset first:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous reset, active-low (asserted when 0).
- ReadEnable, input, 1: fetch request from the core.
- ReadAddress, input, 32: fetch byte address.
- Instruction, output, 32: fetched word; valid only while Ready=1.
- Ready, output, 1: Instruction valid for the current ReadAddress.
- Busy, output, 1: line fill in progress.
- MemReadRequest, output, 1: single-cycle burst request to the instruction memory.
- MemReadAddress, output, 32: line-aligned burst start address.
- MemDataIn, input, 32: burst data word from memory.
- MemDataReady, input, 1: MemDataIn valid this cycle.

Function
REQ-004 Address split: offset = ReadAddress[log2(BLOCK_WORDS)+1:2]; index = next log2(NUM_SETS) bits; tag = remaining upper bits; bits [1:0] SHALL be ignored.
REQ-005 Storage: per line, one valid bit, one tag, and BLOCK_WORDS data words; storage SHALL NOT be reset except for the valid bits.
REQ-006 The FSM SHALL have exactly three states: IDLE, REQ and FILL.
REQ-007 IDLE hit (ReadEnable=1, line valid, tag match): Ready=1 combinationally in the same cycle, Instruction = stored word at the offset, and the FSM SHALL remain in IDLE.
REQ-008 IDLE miss (ReadEnable=1, line invalid or tag mismatch): Ready=0; on the next edge the FSM SHALL latch the ReadAddress line base and enter REQ.
REQ-009 REQ: MemReadRequest=1 for exactly one cycle with MemReadAddress = latched line base (offset and bits [1:0] zero); next state SHALL be FILL.
REQ-010 FILL: each cycle with MemDataReady=1 SHALL write MemDataIn into the word selected by a fill counter (0..BLOCK_WORDS-1) and increment the counter; MemDataReady gaps SHALL be tolerated.
REQ-011 On the edge that captures word BLOCK_WORDS-1, the fill SHALL set the line's valid bit, write the latched tag, clear the counter and return the FSM to IDLE; the retried fetch SHALL hit one cycle later.
REQ-012 Busy SHALL be 1 in REQ and FILL and 0 in IDLE; Ready SHALL be 0 whenever Busy=1.
REQ-013 MemReadRequest SHALL be 0 outside REQ; MemReadAddress SHALL hold the latched base in REQ and FILL.
REQ-014 MemDataReady asserted in IDLE or REQ SHALL be ignored, with no array write and no counter change.
REQ-015 ReadAddress or ReadEnable changes during REQ/FILL SHALL NOT affect the fill in progress; the fill always completes for the latched address.
REQ-016 ReadEnable=0 in IDLE: Ready=0, no state change, no memory request.
REQ-017 Instruction SHALL be 0 when Ready=0.
REQ-018 A fill into a valid line SHALL overwrite that line; there is no write-back and no store path.

Reset
REQ-019 With reset=0, the block SHALL immediately and asynchronously force the FSM to IDLE, clear the fill counter and all valid bits, and drive Ready=0, Busy=0, MemReadRequest=0, MemReadAddress=0 and Instruction=0.
REQ-020 Reset asserted mid-FILL SHALL abandon the fill with the line left invalid; memory words still arriving after reset is released SHALL be ignored per REQ-014.

Verification
REQ-021 The bench SHALL cover these directed scenarios with NUM_SETS=8, BLOCK_WORDS=4, memory first-word delay 40 cycles and words 0xA0..0xA3 at 0x00010000..0x0001000C:
- Cold miss: ReadEnable=1, ReadAddress=0x00010004 -> one MemReadRequest pulse with MemReadAddress=0x00010000; Busy=1 for the fill; Ready=1 with Instruction=0xA1 one cycle after the 4th word.
- Hit after fill: addresses 0x00010000, then 0x0001000C -> Ready=1 in the same cycle, Instruction 0xA0 then 0xA3, no MemReadRequest.
- Conflict: after line 0x00010000 is filled, fetch 0x00010080 (same index 0, new tag) -> miss and refill from 0x00010080; a re-fetch of 0x00010000 then misses again.
- Gapped burst: MemDataReady pattern 1,0,1,1,0,1 -> all 4 words stored in order and Ready=1 exactly once after the last word.
- Reset mid-fill: reset=0 after the 2nd word -> Busy=0 and Ready=0 immediately; the remaining words are ignored; the next fetch of 0x00010000 issues a fresh MemReadRequest.
- Stray data: MemDataReady=1 in IDLE with MemDataIn=0xDEADBEEF -> no hit is created and array contents are unchanged.
